imem_loadable: RTL and testbench

- Parametrised successor to the fixed byte-array instruction memory: byte-addressed, little-endian, synchronous-read instruction store.
- Contents are written at run time through a byte-stream loader port instead of a fixed initial image.
- Fetch side is a pipelined req/valid interface with alignment and range fault reporting.
- Sits between the PC/fetch stage and the boot/debug loader.

---
 rtl/imem_loadable.sv | 164 ++++++++++++++++
 tb/tb_imem_loadable.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// Byte-addressed, little-endian instruction store, filled at run time by a byte-stream loader.
// Optional IMEM_CHECKSUM_EN adds load_checksum: mod-256 sum of the bytes actually written.
module imem_loadable #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 16384,
  parameter int INSTR_BYTES = 4,
  parameter logic [8*INSTR_BYTES-1:0] NOP_WORD = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [ADDR_WIDTH-1:0]    fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [8*INSTR_BYTES-1:0] fetch_data,
  output logic [1:0]               fetch_fault,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_busy,
  output logic                     load_overflow
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [7:0]               load_checksum
`endif
);

  localparam int IDXW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0]   INSTR_EXT  = (ADDR_WIDTH+1)'(INSTR_BYTES);

  typedef enum logic {RUN, LOAD} state_e;

  typedef struct packed {
    logic [1:0]               fault;
    logic [8*INSTR_BYTES-1:0] data;
  } fetch_rsp_t;

  state_e     state_q, state_d;
  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  // Pointer carries one extra bit so it can sit at DEPTH_BYTES once full.
  logic [IDXW:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          vld_q;
  fetch_rsp_t    rsp_q, rsp_d;

  logic                     byte_acc, wr_en, fetch_acc;
  logic                     misaligned, out_range;
  logic [ADDR_WIDTH:0]      end_addr;
  logic [IDXW-1:0]          rd_base;
  logic [8*INSTR_BYTES-1:0] rd_word;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next state; a restart beats a final byte in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (load_start) state_d = LOAD;
      LOAD:    if (byte_acc && load_last && !load_start) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    load_busy   = 1'b0;
    case (state_q)
      RUN:  fetch_ready = 1'b1;
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_acc = load_valid & load_ready;
  assign wr_en    = byte_acc & ~ptr_q[IDXW];

  always_comb begin
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (byte_acc) begin
      if (wr_en) ptr_d = ptr_q + (IDXW+1)'(1);
      else       ovf_d = 1'b1;
    end
    if (load_start) begin
      ptr_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q[IDXW-1:0]] <= load_byte;
  end

  assign load_overflow = ovf_q;

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] ck_q, ck_d;
  always_comb begin
    ck_d = ck_q;
    if (wr_en)      ck_d = ck_q + load_byte;
    if (load_start) ck_d = 8'h00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ck_q <= 8'h00;
    else       ck_q <= ck_d;
  end
  assign load_checksum = ck_q;
`endif

  // Range check at ADDR_WIDTH+1 bits so addresses near the top cannot wrap into range.
  assign fetch_acc  = fetch_req & fetch_ready;
  assign end_addr   = {1'b0, fetch_addr} + INSTR_EXT;
  assign misaligned = (fetch_addr & ALIGN_MASK) != '0;
  assign out_range  = end_addr > DEPTH_EXT;
  assign rd_base    = fetch_addr[IDXW-1:0];

  for (genvar b = 0; b < INSTR_BYTES; b++) begin : g_lane
    assign rd_word[8*b +: 8] = mem[rd_base + IDXW'(b)];
  end

  always_comb begin
    rsp_d.fault = {out_range, misaligned};
    rsp_d.data  = (misaligned || out_range) ? NOP_WORD : rd_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      vld_q <= fetch_acc;
      if (fetch_acc) rsp_q <= rsp_d;
    end
  end

  assign fetch_valid = vld_q;
  assign fetch_data  = rsp_q.data;
  assign fetch_fault = rsp_q.fault;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: a full-size instance plus a 16-byte instance sharing stimulus.
module tb_imem_loadable;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_byte;

  logic        b_fr, b_fv, b_lr, b_lb, b_lo;
  logic [31:0] b_fd;
  logic [1:0]  b_ff;
  logic        s_fr, s_fv, s_lr, s_lb, s_lo;
  logic [31:0] s_fd;
  logic [1:0]  s_ff;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]  b_ck, s_ck;
`endif

  imem_loadable u_big (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(b_fr),
    .fetch_valid(b_fv), .fetch_data(b_fd), .fetch_fault(b_ff),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(b_lr), .load_busy(b_lb), .load_overflow(b_lo)
`ifdef IMEM_CHECKSUM_EN
    , .load_checksum(b_ck)
`endif
  );

  imem_loadable #(.DEPTH_BYTES(16)) u_small (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(s_fr),
    .fetch_valid(s_fv), .fetch_data(s_fd), .fetch_fault(s_ff),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(s_lr), .load_busy(s_lb), .load_overflow(s_lo)
`ifdef IMEM_CHECKSUM_EN
    , .load_checksum(s_ck)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_byte = b; load_last = last;
    cyc();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  logic [7:0] img [8] = '{8'h13, 8'h01, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = '0;
    cyc();
    chk("rst_valid", b_fv, 0);
    chk("rst_data", b_fd, 0);
    chk("rst_fault", b_ff, 0);
    chk("rst_busy", b_lb, 0);
    chk("rst_ovf", b_lo, 0);
    chk("rst_fready", b_fr, 1);
    chk("rst_lready", b_lr, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Basic image load and back-to-back fetch
    start();
    chk("load_busy_on", b_lb, 1);
    chk("load_fready_off", b_fr, 0);
    for (int i = 0; i < 8; i++) begin
      send(img[i], i == 7);
      if (i < 7) chk("load_busy_mid", b_lb, 1);
    end
    chk("load_busy_fall", b_lb, 0);
    chk("load_ovf_none", b_lo, 0);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    cyc();
    chk("f0_valid", b_fv, 1);
    chk("f0_data", b_fd, 32'h00000113);
    chk("f0_fault", b_ff, 0);
    fetch_addr = 32'd4;
    cyc();
    fetch_req = 1'b0;
    chk("f4_valid", b_fv, 1);
    chk("f4_data", b_fd, 32'h00000193);
    chk("f4_fault", b_ff, 0);
    cyc();
    chk("idle_valid", b_fv, 0);
    chk("idle_hold", b_fd, 32'h00000193);

    // Fault boundaries
    fetch(32'd2);
    chk("mis_fault", b_ff, 2'b01);
    chk("mis_data", b_fd, 32'h00000013);
    chk("mis_fault_s", s_ff, 2'b01);
    fetch(32'd16380);
    chk("top_fault", b_ff, 2'b00);
    chk("top_data", b_fd, 32'h0);
    fetch(32'h4000);
    chk("oor_fault", b_ff, 2'b10);
    chk("oor_data", b_fd, 32'h00000013);
    fetch(32'h4001);
    chk("both_fault", b_ff, 2'b11);
    fetch(32'hFFFFFFFC);
    chk("nowrap_fault", b_ff, 2'b10);
    fetch(32'd12);
    chk("s_top_fault", s_ff, 2'b00);
    chk("s_top_data", s_fd, 32'h0);
    fetch(32'd13);
    chk("s_13_fault", s_ff, 2'b11);

    // Overflow on the 16-byte instance
    start();
    for (int i = 1; i <= 20; i++) begin
      send(8'(i), i == 20);
      if (i == 16) chk("ovf_at16", s_lo, 0);
      if (i == 17) chk("ovf_at17", s_lo, 1);
    end
    chk("ovf_sticky", s_lo, 1);
    chk("ovf_big", b_lo, 0);
    chk("ovf_busy", s_lb, 0);
`ifdef IMEM_CHECKSUM_EN
    chk("ck_small_ovf", s_ck, 8'h88);
    chk("ck_big_20", b_ck, 8'hD2);
`endif
    fetch(32'd12);
    chk("ovf_f12", s_fd, 32'h100F0E0D);
    fetch(32'd0);
    chk("ovf_f0", s_fd, 32'h04030201);
    chk("big_f0", b_fd, 32'h04030201);
    fetch(32'd16);
    chk("big_f16", b_fd, 32'h14131211);
    chk("s_f16_fault", s_ff, 2'b10);

    // Reset in the middle of a load
    start();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", b_lb, 0);
    chk("rstmid_fready", b_fr, 1);
    chk("rstmid_ovf", s_lo, 0);
    chk("rstmid_valid", b_fv, 0);
    cyc();
    reset = 1'b0;
    cyc();
    fetch(32'd0);
    chk("rstmid_f0", b_fd, 32'h04A3A2A1);
    chk("rstmid_f0_s", s_fd, 32'h04A3A2A1);

    // Restart on the same cycle as a final byte
    start();
    send(8'hB0, 1'b0);
    send(8'hB1, 1'b0);
    load_start = 1'b1;
    send(8'hB2, 1'b1);
    load_start = 1'b0;
    chk("restart_busy", b_lb, 1);
    send(8'hAA, 1'b1);
    chk("restart_done", b_lb, 0);
    fetch(32'd0);
    chk("restart_f0", b_fd, 32'h04B2B1AA);

    // Fetch accepted alongside load_start, then fetch blocked in LOAD
    fetch_req = 1'b1; fetch_addr = 32'd0; load_start = 1'b1;
    cyc();
    load_start = 1'b0; fetch_addr = 32'd4;
    chk("fl_valid", b_fv, 1);
    chk("fl_data", b_fd, 32'h04B2B1AA);
    chk("fl_busy", b_lb, 1);
    chk("fl_lready", b_lr, 1);
    send(8'hFF, 1'b0);
    fetch_req = 1'b0;
    chk("fl_blocked", b_fv, 0);
    send(8'h02, 1'b0);
    send(8'h10, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    chk("ck_sum", b_ck, 8'h11);
    chk("ck_sum_s", s_ck, 8'h11);
`endif
    fetch(32'd0);
    chk("ck_f0", b_fd, 32'h041002FF);
`ifdef IMEM_CHECKSUM_EN
    chk("ck_hold", b_ck, 8'h11);
`endif
    start();
`ifdef IMEM_CHECKSUM_EN
    chk("ck_clear", b_ck, 8'h00);
`endif
    send(8'h13, 1'b1);
    chk("end_busy", b_lb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
